// File: rtl/seg_pkg.sv
// ============================================================
// seg_pkg: shared seven-segment constants and font lookup
// Revision: 1.0
// ============================================================
`default_nettype none

package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; entry 15 is the leftmost element.
    localparam logic [15:0][6:0] SEG_FONT = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_font(input logic [3:0] nibble);
        return SEG_FONT[nibble];
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_font.sv
// ============================================================
// seg7_font: combinational hex nibble to active-low segment decoder
// Revision: 1.0
// ============================================================
`default_nettype none

module seg7_font
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = seg_font(nibble);

endmodule

`default_nettype wire

// File: rtl/seg_scan_decoder.sv
// ============================================================
// seg_scan_decoder: multiplexed common-anode seven-segment scan driver
// with a valid/ready load port and frame-boundary (tear-free) commit.
// Revision: 1.0
// ============================================================
`default_nettype none

module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   load_data,
    input  logic [DIGITS-1:0]     load_blank,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int PCNT_W = $clog2(PRESCALE);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] pend_data_q, pend_data_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;

    logic                frame_end;
    logic                commit;
    logic                accept;
    logic [3:0]          nibble;
    logic                blank_sel;
    logic [6:0]          font_seg;

    seg7_font u_font (
        .nibble (nibble),
        .seg    (font_seg)
    );

    always_comb begin
        frame_end = (pcnt_q == PCNT_MAX) && (idx_q == IDX_MAX);
        // Disabled display cannot tear, so a pending value commits at once.
        commit    = pend_q && (!en || frame_end);
        accept    = load_valid && !pend_q;

        pcnt_d = '0;
        idx_d  = '0;
        if (en) begin
            if (pcnt_q == PCNT_MAX) begin
                idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
            end else begin
                pcnt_d = pcnt_q + 1'b1;
                idx_d  = idx_q;
            end
        end

        pend_d       = pend_q;
        pend_data_d  = pend_data_q;
        pend_blank_d = pend_blank_q;
        disp_data_d  = disp_data_q;
        disp_blank_d = disp_blank_q;
        if (commit) begin
            disp_data_d  = pend_data_q;
            disp_blank_d = pend_blank_q;
            pend_d       = 1'b0;
        end
        if (accept) begin
            pend_data_d  = load_data;
            pend_blank_d = load_blank;
            pend_d       = 1'b1;
        end

        nibble    = '0;
        blank_sel = 1'b1;
        an_d      = '1;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                nibble    = disp_data_q[4*k +: 4];
                blank_sel = disp_blank_q[k];
                an_d[k]   = !en;
            end
        end
        seg_d = (!en || blank_sel) ? SEG_BLANK : font_seg;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            pend_q       <= 1'b0;
            pend_data_q  <= '0;
            pend_blank_q <= '0;
            disp_data_q  <= '0;
            disp_blank_q <= '1;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            pend_q       <= pend_d;
            pend_data_q  <= pend_data_d;
            pend_blank_q <= pend_blank_d;
            disp_data_q  <= disp_data_d;
            disp_blank_q <= disp_blank_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
        end
    end

    assign load_ready = !pend_q;
    assign an         = an_q;
    assign seg        = seg_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
// ============================================================
// tb_seg_scan_decoder: directed + randomized bench against a timeline model
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_seg_scan_decoder;

    localparam int DIGITS   = 8;
    localparam int PRESCALE = 4;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic [7:0]  load_blank = '0;
    logic        load_ready;
    logic [7:0]  an;
    logic [6:0]  seg;

    always #5 clk = ~clk;

    seg_scan_decoder #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_blank (load_blank),
        .an         (an),
        .seg        (seg)
    );

    // Model: time since enable, shown value, pending value.
    int          ticks;
    bit          m_pend;
    logic [31:0] m_data, p_data;
    logic [7:0]  m_blank, p_blank;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    int          n_checks = 0;
    int          n_pass = 0;
    int          n_fail = 0;
    bit          acc;

    string LIT [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                        "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    function automatic logic [6:0] font_of(input logic [3:0] v);
        string s;
        logic [6:0] r;
        s = LIT[v];
        r = 7'h7F;
        for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
        return r;
    endfunction

    task automatic model_reset();
        ticks   = 0;
        m_pend  = 1'b0;
        m_data  = '0;
        m_blank = '1;
        p_data  = '0;
        p_blank = '0;
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic step(output bit accepted);
        int digit;
        bit commit;
        digit   = (ticks / PRESCALE) % DIGITS;
        exp_an  = 8'hFF;
        if (en) exp_an[digit] = 1'b0;
        exp_seg = (!en || m_blank[digit]) ? 7'h7F : font_of(m_data[digit*4 +: 4]);
        commit   = m_pend && (!en || (ticks % FRAME == FRAME - 1));
        accepted = load_valid && !m_pend;
        @(posedge clk);
        if (commit) begin
            m_data  = p_data;
            m_blank = p_blank;
            m_pend  = 1'b0;
        end
        if (accepted) begin
            p_data  = load_data;
            p_blank = load_blank;
            m_pend  = 1'b1;
        end
        ticks = en ? ticks + 1 : 0;
        #1;
        check("an", an, exp_an);
        check("seg", seg, exp_seg);
        check("load_ready", load_ready, 32'(!m_pend));
    endtask

    task automatic run(input int n);
        bit a;
        repeat (n) step(a);
    endtask

    task automatic do_load(input logic [31:0] d, input logic [7:0] b);
        bit a;
        a = 1'b0;
        load_data  = d;
        load_blank = b;
        load_valid = 1'b1;
        for (int i = 0; i < 4 * FRAME && !a; i++) step(a);
        check("load_accept", 32'(a), 32'd1);
        load_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        en = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("rst_an", an, exp_an);
            check("rst_seg", seg, exp_seg);
            check("rst_ready", load_ready, 32'(!m_pend));
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(FRAME + 4);

        do_load(32'h76543210, 8'h00);
        run(2 * FRAME + 2);

        do_load(32'h11111111, 8'h00);
        run(FRAME + 10);
        do_load(32'h22222222, 8'h00);
        run(FRAME + 4);

        do_load(32'h88888888, 8'h0F);
        run(2 * FRAME);

        for (int i = 0; i < 2 * FRAME && ((ticks / PRESCALE) % DIGITS) != 5; i++) step(acc);
        step(acc);
        en = 1'b0;
        run(3);
        do_load(32'hFEDCBA98, 8'h00);
        run(2);
        en = 1'b1;
        run(2 * FRAME + 2);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 49) == 0) en = ~en;
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = $urandom;
            load_blank = 8'($urandom_range(0, 255));
            step(acc);
        end
        load_valid = 1'b0;
        en = 1'b1;
        run(FRAME);

        do_load(32'hABCDEF01, 8'h00);
        check("pend_before_rst", load_ready, 32'(!m_pend));
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async_an", an, exp_an);
        check("async_seg", seg, exp_seg);
        check("async_ready", load_ready, 32'(!m_pend));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Multiplexed seven-segment display driver: the decode side of the board's LED/segment path. Accepts a packed hex value through a valid/ready load port and scans it across up to eight common-anode digits. Each scan index is decoded to a one-hot, active-low anode select, and the current nibble is decoded to an active-low segment pattern. Sits between core-side status logic and the board display pins.

## Interface
- `DIGITS`, default 8: number of digits scanned; legal range 1..8.
- `PRESCALE`, default 50000: clock cycles each digit is lit; legal range ≥2.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst_n`  in  1: reset; asynchronous, active-low.
- `en`  in  1: display enable; low blanks all outputs and holds the scan at digit 0.
- `load_valid`  in  1: a new value is offered on `load_data`/`load_blank`.
- `load_ready`  out  1: the block can accept a load this cycle.
- `load_data`  in  4*DIGITS: nibble k (bits 4k+3:4k) drives digit k.
- `load_blank`  in  DIGITS: bit k=1 blanks digit k (segments off, anode still scanned).
- `an`  out  DIGITS: anode select, active-low, one-hot-low while scanning.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- State: prescaler `pcnt` (0..PRESCALE-1), digit index `idx` (0..DIGITS-1), display regs (`disp_data`, `disp_blank`), pending regs plus `pend` flag.
- Load handshake: `load_ready = !pend`. A load is accepted when `load_valid && load_ready`; data and blank are captured into the pending regs and `pend` is set.
- Commit: while `en`=1, pending regs copy to display regs on the frame boundary (cycle where `pcnt==PRESCALE-1 && idx==DIGITS-1`), and `pend` clears. While `en`=0, commit happens on the first cycle `pend` is set. No torn frames.
- Scan: when `en`=1, `pcnt` increments each cycle. At `PRESCALE-1` it wraps to 0 and `idx` advances, wrapping `DIGITS-1`→0.
- When `en`=0, `pcnt` and `idx` are forced to 0.
- Anode decode: `an[k]=0` iff `en && k==idx`; otherwise 1.
- Segment decode: if `!en` or `disp_blank[idx]`, `seg=7'h7F`. Otherwise `seg` is the font of `disp_data[idx]`, with lit segments per digit:
  - 0:abcdef, 1:bc, 2:abdeg, 3:abcdg
  - 4:bcfg, 5:acdfg, 6:acdefg, 7:abc
  - 8:abcdefg, 9:abcdfg, A:abcefg, b:cdefg
  - C:adef, d:bcdeg, E:adefg, F:aefg
- Reset values:
  - `an` all 1, `seg=7'h7F`, `load_ready=1`.
  - `pcnt=0`, `idx=0`, `pend=0`.
  - `disp_data=0`, `disp_blank` all 1 (dark display), pending regs 0.

## Timing
- `an`/`seg` are registered: they reflect the `idx` and display regs of the previous cycle.
- Digit k is lit for exactly PRESCALE cycles. Frame period is DIGITS*PRESCALE cycles.
- Load latency: acceptance at cycle t gives `load_ready=0` from t+1.
  - With `en`=1, the new value appears on `seg` in the cycle after the next frame boundary's digit-0 update (≤ DIGITS*PRESCALE+1 cycles after acceptance).
  - `load_ready` returns to 1 the cycle after commit.
- A commit and a new `load_valid` in the same cycle: no acceptance (`load_ready` is still 0). The load is accepted the next cycle if `load_valid` is held.
- `en` falling mid-frame: outputs blank on the next edge; `pcnt`/`idx` reset to 0. `en` rising restarts at digit 0 with a full PRESCALE dwell.
- `rst_n` assertion mid-operation immediately forces all reset values, including dropping any pending load. Release is synchronous to the `clk` edge.
- DIGITS=1: every PRESCALE wrap is a frame boundary.

## Structure
- Shared package `seg_pkg`:
  - `SEG_BLANK = 7'h7F`
  - 16-entry active-low font constant `SEG_FONT`
  - function `seg_font(nibble)`
- Sub-module `seg7_font`: combinational nibble→segment decoder built on `seg_pkg`. It is instantiated once on the muxed nibble.
- Top holds the prescaler, index counter, pending/display registers, handshake and output registers.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with `en`=1 -> `an`=8'hFF, `seg`=7'h7F, `load_ready`=1; after release the display stays dark (all blank) through a full frame.
- Basic scan (PRESCALE=4): load `load_data`=32'h76543210, `load_blank`=0, `en`=1 -> after commit, `an` walks FE,FD,…,7F with 4 cycles each; `seg` shows 0x40,0x79,0x24,0x30,0x19,0x12,0x02,0x78.
- Handshake/tear-free: load 32'h11111111, then offer 32'h22222222 mid-frame -> `load_ready`=0 until the frame boundary; no digit shows 2 before digit 0 of the next frame.
- Blank mask: `load_blank`=8'h0F with data 32'h88888888 -> digits 0–3 show `seg`=7'h7F with anodes still cycling; digits 4–7 show 7'h00.
- Enable toggle: drop `en` during digit 5 -> next cycle `an`=8'hFF, `seg`=7'h7F. Raise `en` -> digit 0 lit for a full 4 cycles. A load offered while `en`=0 commits in 1 cycle (`load_ready` high again 2 cycles after acceptance).
- Async reset mid-frame with `pend`=1: assert `rst_n`=0 between clock edges -> outputs go to reset values immediately; the pending value is never displayed.
